// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer sequencer: FSM state
// encoding and a width helper used for parameter defaults.
package nn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4
  } nn_state_e;

  // Bits needed to index 'value' items, never less than one bit.
  function automatic int nn_clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/nn_sample_counter.sv
// Sample address counter for one batch. Counts 0..NUM_SAMPLES-1 and keeps a
// registered is_last flag so the sequencer's end-of-batch decision needs no
// wide compare in the control path.
module nn_sample_counter
  import nn_pkg::*;
#(
  parameter int NUM_SAMPLES = 750,
  parameter int SAMPLE_W    = nn_clog2(NUM_SAMPLES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clear,
  input  logic                i_inc,
  output logic [SAMPLE_W-1:0] o_addr,
  output logic                o_is_last
);

  localparam logic [SAMPLE_W-1:0] LAST_ADDR = SAMPLE_W'(NUM_SAMPLES - 1);
  localparam logic                ONLY_ONE  = (NUM_SAMPLES == 1);

  logic [SAMPLE_W-1:0] r_addr;
  logic                r_is_last;
  logic [SAMPLE_W-1:0] w_addr_inc;

  assign w_addr_inc = r_addr + SAMPLE_W'(1);

  // Address register: clear wins over increment; increment stops at the last sample.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_is_last <= ONLY_ONE;
    end else if (i_clear) begin
      r_addr    <= '0;
      r_is_last <= ONLY_ONE;
    end else if (i_inc && !r_is_last) begin
      r_addr    <= w_addr_inc;
      r_is_last <= (w_addr_inc == LAST_ADDR);
    end
  end

  assign o_addr    = r_addr;
  assign o_is_last = r_is_last;

endmodule

// File: rtl/nn_layer_sequencer.sv
// Batch/layer sequencer: fetches each sample, launches every layer in turn
// on the shared neuron array and reports sample and batch completion.
module nn_layer_sequencer
  import nn_pkg::*;
#(
  parameter int NUM_LAYERS  = 3,
  parameter int NUM_SAMPLES = 750,
  parameter int SAMPLE_W    = nn_clog2(NUM_SAMPLES),
  parameter int LAYER_W     = nn_clog2(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  sample_vld,
  input  logic                  calc_done,
  output logic                  sample_req,
  output logic [SAMPLE_W-1:0]   sample_addr,
  output logic                  start_neuron,
  output logic [LAYER_W-1:0]    layer_idx,
  output logic                  hidden,
  output logic [NUM_LAYERS-2:0] ld_en,
  output logic                  sample_done,
  output logic                  batch_done,
  output logic                  idle
);

  localparam int                 HIDDEN_N   = NUM_LAYERS - 1;
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [HIDDEN_N-1:0] LD_ONE    = HIDDEN_N'(1);

  nn_state_e           r_state;
  logic [LAYER_W-1:0]  r_layer_idx;
  logic                w_cnt_clear;
  logic                w_cnt_inc;
  logic                w_is_last;
  logic [SAMPLE_W-1:0] w_addr;

  // Sample counter restarts on batch start, abort and batch end; it advances
  // only when a non-final sample finishes.
  assign w_cnt_clear = abort
                     | ((r_state == ST_IDLE) & start)
                     | ((r_state == ST_NEXT) & w_is_last);
  assign w_cnt_inc   = ~abort & (r_state == ST_NEXT) & ~w_is_last;

  nn_sample_counter #(
    .NUM_SAMPLES (NUM_SAMPLES),
    .SAMPLE_W    (SAMPLE_W)
  ) u_sample_counter (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_cnt_clear),
    .i_inc     (w_cnt_inc),
    .o_addr    (w_addr),
    .o_is_last (w_is_last)
  );

  // Sequencer FSM and layer counter; abort returns to IDLE from anywhere.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_layer_idx <= '0;
    end else if (abort) begin
      r_state     <= ST_IDLE;
      r_layer_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state     <= ST_FETCH;
            r_layer_idx <= '0;
          end
        end
        ST_FETCH: begin
          if (sample_vld) r_state <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (calc_done) begin
            if (r_layer_idx == LAST_LAYER) begin
              r_state     <= ST_NEXT;
              r_layer_idx <= '0;
            end else begin
              r_state     <= ST_LAUNCH;
              r_layer_idx <= r_layer_idx + LAYER_W'(1);
            end
          end
        end
        ST_NEXT: begin
          r_state <= w_is_last ? ST_IDLE : ST_FETCH;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_layer_idx <= '0;
        end
      endcase
    end
  end

  // Moore output decode from the registered state and counters.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    idle         = 1'b0;
    sample_req   = 1'b0;
    start_neuron = 1'b0;
    sample_done  = 1'b0;
    batch_done   = 1'b0;
    case (r_state)
      ST_IDLE:   idle         = 1'b1;
      ST_FETCH:  sample_req   = 1'b1;
      ST_LAUNCH: start_neuron = 1'b1;
      ST_WAIT:   start_neuron = 1'b1;
      ST_NEXT: begin
        sample_done = 1'b1;
        batch_done  = w_is_last;
      end
      default: idle = 1'b0;
    endcase
    hidden = start_neuron && (r_layer_idx < LAST_LAYER);
    ld_en  = start_neuron ? (LD_ONE << r_layer_idx) : '0;
  end

  assign sample_addr = w_addr;
  assign layer_idx   = r_layer_idx;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Self-checking bench for nn_layer_sequencer: a 3-layer/4-sample instance
// driven with randomized handshake timing and stray inputs, plus a
// 5-layer/1-sample instance. Expected outputs come from the layer/sample
// position the bench itself has walked the DUT to.
module tb_nn_layer_sequencer;

  localparam int NL_A = 3;
  localparam int NS_A = 4;
  localparam int NL_B = 5;

  logic clk = 1'b0;
  logic rst;

  logic       a_start, a_abort, a_sample_vld, a_calc_done;
  logic       a_sample_req, a_start_neuron, a_hidden, a_sample_done, a_batch_done, a_idle;
  logic [1:0] a_sample_addr;
  logic [1:0] a_layer_idx;
  logic [1:0] a_ld_en;

  logic       b_start, b_abort, b_sample_vld, b_calc_done;
  logic       b_sample_req, b_start_neuron, b_hidden, b_sample_done, b_batch_done, b_idle;
  logic [0:0] b_sample_addr;
  logic [2:0] b_layer_idx;
  logic [3:0] b_ld_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nn_layer_sequencer #(
    .NUM_LAYERS(NL_A), .NUM_SAMPLES(NS_A), .SAMPLE_W(2), .LAYER_W(2)
  ) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .sample_vld(a_sample_vld), .calc_done(a_calc_done),
    .sample_req(a_sample_req), .sample_addr(a_sample_addr),
    .start_neuron(a_start_neuron), .layer_idx(a_layer_idx),
    .hidden(a_hidden), .ld_en(a_ld_en), .sample_done(a_sample_done),
    .batch_done(a_batch_done), .idle(a_idle)
  );

  nn_layer_sequencer #(
    .NUM_LAYERS(NL_B), .NUM_SAMPLES(1), .SAMPLE_W(1), .LAYER_W(3)
  ) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .sample_vld(b_sample_vld), .calc_done(b_calc_done),
    .sample_req(b_sample_req), .sample_addr(b_sample_addr),
    .start_neuron(b_start_neuron), .layer_idx(b_layer_idx),
    .hidden(b_hidden), .ld_en(b_ld_en), .sample_done(b_sample_done),
    .batch_done(b_batch_done), .idle(b_idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: layer L is hidden unless it is the output layer; hidden layer L
  // owns load-enable bit L.
  function automatic logic [31:0] exp_hidden(input int l, input int nl);
    return (l < nl - 1) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] exp_ld(input int l, input int nl);
    return (l < nl - 1) ? (32'd1 << l) : 32'd0;
  endfunction

  task automatic chk_layer_a(input string tag, input int l, input int s);
    chk({tag, "_start_neuron"}, a_start_neuron, 1);
    chk({tag, "_layer_idx"},    a_layer_idx, l);
    chk({tag, "_hidden"},       a_hidden, exp_hidden(l, NL_A));
    chk({tag, "_ld_en"},        a_ld_en, exp_ld(l, NL_A));
    chk({tag, "_sample_req"},   a_sample_req, 0);
    chk({tag, "_sample_addr"},  a_sample_addr, s);
    chk({tag, "_sample_done"},  a_sample_done, 0);
    chk({tag, "_idle"},         a_idle, 0);
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_idle"},         a_idle, 1);
    chk({tag, "_sample_addr"},  a_sample_addr, 0);
    chk({tag, "_layer_idx"},    a_layer_idx, 0);
    chk({tag, "_sample_req"},   a_sample_req, 0);
    chk({tag, "_start_neuron"}, a_start_neuron, 0);
    chk({tag, "_hidden"},       a_hidden, 0);
    chk({tag, "_ld_en"},        a_ld_en, 0);
    chk({tag, "_sample_done"},  a_sample_done, 0);
    chk({tag, "_batch_done"},   a_batch_done, 0);
  endtask

  // One sample on instance A, entered in its first FETCH cycle. fwait/w < 0
  // pick random fetch delay / per-layer WAIT length. Ignored inputs are
  // toggled randomly wherever the sequencer must not react to them.
  task automatic run_sample_a(input int s, input int fwait, input int w);
    int fw;
    int wl;
    fw = (fwait < 0) ? int'($urandom_range(0, 3)) : fwait;
    for (int k = 0; k < fw; k++) begin
      chk("fetch_req", a_sample_req, 1);
      chk("fetch_addr", a_sample_addr, s);
      chk("fetch_sn", a_start_neuron, 0);
      a_sample_vld = 1'b0;
      a_calc_done  = 1'($urandom_range(0, 1));
      a_start      = 1'($urandom_range(0, 1));
      tick();
    end
    chk("fetch_req", a_sample_req, 1);
    chk("fetch_addr", a_sample_addr, s);
    a_sample_vld = 1'b1;
    a_calc_done  = 1'($urandom_range(0, 1));
    tick();
    for (int l = 0; l < NL_A; l++) begin
      chk_layer_a("launch", l, s);
      a_sample_vld = 1'($urandom_range(0, 1));
      a_calc_done  = 1'($urandom_range(0, 1));
      tick();
      wl = (w < 0) ? int'($urandom_range(0, 4)) : w;
      for (int k = 0; k < wl; k++) begin
        chk_layer_a("wait", l, s);
        a_sample_vld = 1'($urandom_range(0, 1));
        a_calc_done  = 1'b0;
        tick();
      end
      chk_layer_a("wait_done", l, s);
      a_sample_vld = 1'b0;
      a_calc_done  = 1'b1;
      tick();
    end
    a_calc_done  = 1'b0;
    a_sample_vld = 1'b0;
    a_start      = 1'b0;
    chk("next_sample_done", a_sample_done, 1);
    chk("next_batch_done", a_batch_done, (s == NS_A - 1) ? 1 : 0);
    chk("next_addr", a_sample_addr, s);
    chk("next_layer_idx", a_layer_idx, 0);
    chk("next_sn", a_start_neuron, 0);
    tick();
  endtask

  task automatic run_batch_a(input int fwait, input int w);
    chk("batch_pre_idle", a_idle, 1);
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int s = 0; s < NS_A; s++) run_sample_a(s, fwait, w);
    chk("batch_end_idle", a_idle, 1);
    chk("batch_end_addr", a_sample_addr, 0);
    chk("batch_end_sd", a_sample_done, 0);
    chk("batch_end_bd", a_batch_done, 0);
  endtask

  initial begin
    int done_cyc[4];
    int n_done;
    int n_bd;
    int bd_cyc;

    rst = 1'b1;
    {a_start, a_abort, a_sample_vld, a_calc_done} = '0;
    {b_start, b_abort, b_sample_vld, b_calc_done} = '0;

    // Reset values
    repeat (3) tick();
    chk_reset_a("reset");
    chk("reset_b_idle", b_idle, 1);
    chk("reset_b_ld_en", b_ld_en, 0);
    rst = 1'b0;
    tick();
    chk_reset_a("post_reset");

    // Directed timing: fetch 2 cycles, calc_done 5 cycles after LAUNCH
    run_batch_a(2, 4);

    // Randomized batches with stray inputs
    repeat (3) run_batch_a(-1, -1);

    // Back-to-back timing: per-sample period must be 8 cycles
    a_sample_vld = 1'b1;
    a_calc_done  = 1'b1;
    a_start      = 1'b1;
    tick();
    a_start = 1'b0;
    n_done = 0;
    n_bd   = 0;
    bd_cyc = -1;
    for (int c = 1; c <= 60; c++) begin
      if (a_idle) break;
      if (a_sample_done) begin
        if (n_done < 4) done_cyc[n_done] = c;
        n_done++;
      end
      if (a_batch_done) begin
        n_bd++;
        bd_cyc = c;
        chk("period_bd_addr", a_sample_addr, NS_A - 1);
      end
      tick();
    end
    a_sample_vld = 1'b0;
    a_calc_done  = 1'b0;
    chk("period_n_done", n_done, NS_A);
    chk("period_n_bd", n_bd, 1);
    if (n_done == NS_A) begin
      for (int i = 1; i < NS_A; i++) chk("period_len", done_cyc[i] - done_cyc[i-1], 8);
      chk("period_bd_with_last", bd_cyc, done_cyc[NS_A-1]);
    end
    chk("period_end_idle", a_idle, 1);

    // Abort during WAIT of sample 2, layer 1
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    run_sample_a(0, -1, -1);
    run_sample_a(1, -1, -1);
    chk("ab_fetch_addr", a_sample_addr, 2);
    a_sample_vld = 1'b1;
    tick();
    a_sample_vld = 1'b0;
    chk_layer_a("ab_l0_launch", 0, 2);
    tick();
    a_calc_done = 1'b1;
    tick();
    a_calc_done = 1'b0;
    chk_layer_a("ab_l1_launch", 1, 2);
    tick();
    chk_layer_a("ab_l1_wait", 1, 2);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk_reset_a("abort");
    repeat (2) begin
      tick();
      chk("abort_quiet_sd", a_sample_done, 0);
      chk("abort_quiet_bd", a_batch_done, 0);
      chk("abort_quiet_idle", a_idle, 1);
    end

    // start and abort together in IDLE: stays IDLE
    a_start = 1'b1;
    a_abort = 1'b1;
    tick();
    a_start = 1'b0;
    a_abort = 1'b0;
    chk("start_abort_idle", a_idle, 1);
    chk("start_abort_req", a_sample_req, 0);
    tick();
    chk("start_abort_idle2", a_idle, 1);

    // Async reset mid-LAUNCH of sample 1, away from the clock edge
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    run_sample_a(0, 0, 0);
    a_sample_vld = 1'b1;
    tick();
    a_sample_vld = 1'b0;
    chk_layer_a("rst_launch", 0, 1);
    #2 rst = 1'b1;
    #1;
    chk_reset_a("async_rst");
    #3 rst = 1'b0;
    tick();
    chk_reset_a("after_rst");
    run_batch_a(-1, -1);

    // Five-layer, single-sample instance
    chk("b_idle", b_idle, 1);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    chk("b_fetch_req", b_sample_req, 1);
    b_sample_vld = 1'b1;
    tick();
    b_sample_vld = 1'b0;
    for (int l = 0; l < NL_B; l++) begin
      for (int ph = 0; ph < 2; ph++) begin
        chk("b_start_neuron", b_start_neuron, 1);
        chk("b_layer_idx", b_layer_idx, l);
        chk("b_hidden", b_hidden, exp_hidden(l, NL_B));
        chk("b_ld_en", b_ld_en, exp_ld(l, NL_B));
        chk("b_sample_done", b_sample_done, 0);
        b_calc_done = (ph == 1);
        tick();
      end
    end
    b_calc_done = 1'b0;
    chk("b_sample_done_end", b_sample_done, 1);
    chk("b_batch_done_end", b_batch_done, 1);
    chk("b_addr_end", b_sample_addr, 0);
    tick();
    chk("b_idle_end", b_idle, 1);
    chk("b_sd_after", b_sample_done, 0);
    chk("b_bd_after", b_batch_done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
